// File: rtl/dafx_stereo_gain_if.sv
// Interleaved stereo sample stream around the gain stage: ingress (ing_*) and egress (egr_*) beats.
// The slave view belongs to the gain stage; the master view is its upstream/downstream environment.
interface dafx_stereo_gain_if #(
    parameter int AUDIO_WIDTH_P = 24
);
    logic [AUDIO_WIDTH_P-1:0] ing_data;
    logic                     ing_valid;
    logic                     ing_ready;
    logic                     ing_last;
    logic [AUDIO_WIDTH_P-1:0] egr_data;
    logic                     egr_valid;
    logic                     egr_ready;
    logic                     egr_last;

    modport slave (
        input  ing_data, ing_valid, ing_last, egr_ready,
        output ing_ready, egr_data, egr_valid, egr_last
    );

    modport master (
        output ing_data, ing_valid, ing_last, egr_ready,
        input  ing_ready, egr_data, egr_valid, egr_last
    );
endinterface

// File: rtl/dafx_stereo_gain.sv
// Per-channel gain and mute for the interleaved stereo DAC stream, with per-frame setting
// snapshot, floor-rounded fixed-point scaling and output saturation.
module dafx_stereo_gain #(
    parameter int AUDIO_WIDTH_P = 24,
    parameter int GAIN_WIDTH_P  = 16,
    parameter int GAIN_Q_BITS_P = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [GAIN_WIDTH_P-1:0] cfg_gain_left,
    input  logic [GAIN_WIDTH_P-1:0] cfg_gain_right,
    input  logic                    cfg_mute,
    input  logic                    sat_clr,
    dafx_stereo_gain_if.slave       bus,
    output logic [15:0]             sat_count
);
    localparam int PROD_WIDTH = AUDIO_WIDTH_P + GAIN_WIDTH_P;
    localparam logic [GAIN_WIDTH_P-1:0] UNITY_GAIN =
        {{(GAIN_WIDTH_P-1){1'b0}}, 1'b1} << GAIN_Q_BITS_P;

    // Returns {saturated_flag, clamped_sample}.
    function automatic logic [AUDIO_WIDTH_P:0] saturate(input logic signed [PROD_WIDTH-1:0] value);
        logic signed [PROD_WIDTH-1:0] pos_lim;
        logic signed [PROD_WIDTH-1:0] neg_lim;
        pos_lim = {{(PROD_WIDTH-AUDIO_WIDTH_P+1){1'b0}}, {(AUDIO_WIDTH_P-1){1'b1}}};
        neg_lim = {{(PROD_WIDTH-AUDIO_WIDTH_P+1){1'b1}}, {(AUDIO_WIDTH_P-1){1'b0}}};
        if (value > pos_lim) begin
            saturate = {1'b1, 1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
        end else if (value < neg_lim) begin
            saturate = {1'b1, 1'b1, {(AUDIO_WIDTH_P-1){1'b0}}};
        end else begin
            saturate = {1'b0, value[AUDIO_WIDTH_P-1:0]};
        end
    endfunction

    logic                         s1_valid;
    logic [PROD_WIDTH-1:0]        s1_product;
    logic                         s1_last;
    logic                         s1_mute;
    logic                         frame_start;
    logic [GAIN_WIDTH_P-1:0]      gain_left_act;
    logic [GAIN_WIDTH_P-1:0]      gain_right_act;
    logic                         mute_act;
    logic                         s2_load;
    logic                         s1_load;
    logic                         accept;
    logic                         sat_inc;
    logic [GAIN_WIDTH_P-1:0]      gain_sel;
    logic                         mute_sel;
    logic [PROD_WIDTH-1:0]        product;
    logic signed [PROD_WIDTH-1:0] shifted;
    logic [AUDIO_WIDTH_P:0]       sat_result;

    // Pipeline advance conditions; ready is forced low while in reset.
    always_comb begin
        s2_load = !bus.egr_valid || bus.egr_ready;
        s1_load = !s1_valid || s2_load;
        accept  = bus.ing_valid && rst_n && s1_load;
    end

    assign bus.ing_ready = rst_n && s1_load;

    // First beat of a frame sees the live cfg values, the rest of the frame the snapshot.
    always_comb begin
        if (frame_start) begin
            gain_sel = bus.ing_last ? cfg_gain_right : cfg_gain_left;
            mute_sel = cfg_mute;
        end else begin
            gain_sel = bus.ing_last ? gain_right_act : gain_left_act;
            mute_sel = mute_act;
        end
        // Sign-extended operands: the low PROD_WIDTH bits equal the signed product.
        product    = {{GAIN_WIDTH_P{bus.ing_data[AUDIO_WIDTH_P-1]}}, bus.ing_data}
                   * {{AUDIO_WIDTH_P{gain_sel[GAIN_WIDTH_P-1]}}, gain_sel};
        shifted    = $signed(s1_product) >>> GAIN_Q_BITS_P;
        sat_result = saturate(shifted);
        sat_inc    = s2_load && s1_valid && !s1_mute && sat_result[AUDIO_WIDTH_P];
    end

    // Frame snapshot of gains and mute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start    <= 1'b1;
            gain_left_act  <= UNITY_GAIN;
            gain_right_act <= UNITY_GAIN;
            mute_act       <= 1'b0;
        end else if (accept) begin
            frame_start <= bus.ing_last;
            if (frame_start) begin
                gain_left_act  <= cfg_gain_left;
                gain_right_act <= cfg_gain_right;
                mute_act       <= cfg_mute;
            end
        end
    end

    // Stage 1: full-precision product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_product <= {PROD_WIDTH{1'b0}};
            s1_last    <= 1'b0;
            s1_mute    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_product <= product;
                s1_last    <= bus.ing_last;
                s1_mute    <= mute_sel;
            end
        end
    end

    // Stage 2: rescale, saturate, mute; held while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.egr_valid <= 1'b0;
            bus.egr_data  <= {AUDIO_WIDTH_P{1'b0}};
            bus.egr_last  <= 1'b0;
        end else if (s2_load) begin
            bus.egr_valid <= s1_valid;
            if (s1_valid) begin
                bus.egr_data <= s1_mute ? {AUDIO_WIDTH_P{1'b0}} : sat_result[AUDIO_WIDTH_P-1:0];
                bus.egr_last <= s1_last;
            end
        end
    end

    // Saturation event counter, sticky at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= 16'h0000;
        end else if (sat_clr) begin
            sat_count <= 16'h0000;
        end else if (sat_inc && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'h0001;
        end
    end
endmodule

// File: tb/tb_dafx_stereo_gain.sv
// Directed self-checking bench for dafx_stereo_gain: gain scaling, saturation, frame
// snapshot, backpressure, mute and mid-stream reset.
module tb_dafx_stereo_gain;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_gain_left;
    logic [15:0] cfg_gain_right;
    logic        cfg_mute;
    logic        sat_clr;
    logic [15:0] sat_count;
    int          checks = 0;
    int          errors = 0;
    logic [24:0] outq[$];
    logic [31:0] snap_data;

    dafx_stereo_gain_if bus ();

    dafx_stereo_gain dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_gain_left  (cfg_gain_left),
        .cfg_gain_right (cfg_gain_right),
        .cfg_mute       (cfg_mute),
        .sat_clr        (sat_clr),
        .bus            (bus),
        .sat_count      (sat_count)
    );

    always #5 clk = ~clk;

    // Output beats are recorded on the falling edge, ahead of the edge that transfers them.
    always @(negedge clk) begin
        if (bus.egr_valid && bus.egr_ready) outq.push_back({bus.egr_last, bus.egr_data});
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] beat(input logic last, input logic [23:0] data);
        return {7'd0, last, data};
    endfunction

    task automatic send(input logic [23:0] data, input logic last);
        int  n;
        logic ok;
        bus.ing_data  = data;
        bus.ing_last  = last;
        bus.ing_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            ok = bus.ing_ready;
        end
        @(posedge clk);
        #1;
        bus.ing_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (outq.size() < n && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("wait_out", 32'(outq.size() >= n), 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] expected);
        if (outq.size() > 0) check(tag, 32'(outq.pop_front()), expected);
        else check(tag, 32'hDEAD_BEEF, expected);
    endtask

    initial begin
        rst_n          = 1'b0;
        cfg_gain_left  = 16'h1000;
        cfg_gain_right = 16'h1000;
        cfg_mute       = 1'b0;
        sat_clr        = 1'b0;
        bus.ing_data   = 24'h000000;
        bus.ing_valid  = 1'b0;
        bus.ing_last   = 1'b0;
        bus.egr_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_egr_valid", 32'(bus.egr_valid), 32'd0);
        check("rst_egr_data", 32'(bus.egr_data), 32'd0);
        check("rst_egr_last", 32'(bus.egr_last), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_ing_ready", 32'(bus.ing_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ing_ready", 32'(bus.ing_ready), 32'd1);

        // Per-channel gains and two-cycle latency.
        cfg_gain_left  = 16'h0800;
        cfg_gain_right = 16'h1000;
        send(24'h100000, 1'b0);
        check("latency_s1_only", 32'(bus.egr_valid), 32'd0);
        send(24'h100000, 1'b1);
        check("latency_s2", 32'(bus.egr_valid), 32'd1);
        wait_out(2);
        pop_check("gain_left_half", beat(1'b0, 24'h080000));
        pop_check("gain_right_unity", beat(1'b1, 24'h100000));

        // Saturation both directions, counter and clear.
        cfg_gain_left  = 16'h4000;
        cfg_gain_right = 16'h4000;
        send(24'h400000, 1'b0);
        send(24'hC00000, 1'b1);
        wait_out(2);
        pop_check("sat_pos", beat(1'b0, 24'h7FFFFF));
        pop_check("sat_neg", beat(1'b1, 24'h800000));
        check("sat_count_2", 32'(sat_count), 32'd2);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_count_clr", 32'(sat_count), 32'd0);

        // Floor rounding.
        cfg_gain_left  = 16'h0800;
        cfg_gain_right = 16'h0800;
        send(24'hFFFFFF, 1'b0);
        send(24'h000001, 1'b1);
        wait_out(2);
        pop_check("floor_neg_half", beat(1'b0, 24'hFFFFFF));
        pop_check("floor_pos_half", beat(1'b1, 24'h000000));

        // Mid-frame config change only takes effect next frame.
        cfg_gain_left  = 16'h1000;
        cfg_gain_right = 16'h1000;
        send(24'h000100, 1'b0);
        cfg_gain_right = 16'h2000;
        send(24'h000100, 1'b1);
        send(24'h000100, 1'b0);
        send(24'h000100, 1'b1);
        wait_out(4);
        pop_check("snap_l0", beat(1'b0, 24'h000100));
        pop_check("snap_r0_old_gain", beat(1'b1, 24'h000100));
        pop_check("snap_l1", beat(1'b0, 24'h000100));
        pop_check("snap_r1_new_gain", beat(1'b1, 24'h000200));

        // Backpressure: egr_ready low for five cycles during a six-beat burst.
        cfg_gain_right = 16'h1000;
        bus.egr_ready  = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(24'(i), 1'((i % 2) == 0));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                check("bp_ing_ready_low", 32'(bus.ing_ready), 32'd0);
                check("bp_egr_valid", 32'(bus.egr_valid), 32'd1);
                snap_data = 32'(bus.egr_data);
                check("bp_first_data", snap_data, 32'h000001);
                repeat (3) @(posedge clk);
                #1;
                check("bp_data_held", 32'(bus.egr_data), snap_data);
                check("bp_still_stalled", 32'(bus.ing_ready), 32'd0);
                bus.egr_ready = 1'b1;
            end
        join
        wait_out(6);
        for (int i = 1; i <= 6; i++) pop_check("bp_order", beat(1'((i % 2) == 0), 24'(i)));

        // Mute overrides saturation and does not count.
        cfg_gain_left  = 16'h4000;
        cfg_gain_right = 16'h4000;
        cfg_mute       = 1'b1;
        send(24'h7FFFFF, 1'b0);
        send(24'h7FFFFF, 1'b1);
        wait_out(2);
        pop_check("mute_l", beat(1'b0, 24'h000000));
        pop_check("mute_r", beat(1'b1, 24'h000000));
        check("mute_no_sat", 32'(sat_count), 32'd0);
        cfg_mute = 1'b0;

        // Reset mid-frame discards the pipeline and re-arms the snapshot.
        cfg_gain_left  = 16'h2000;
        cfg_gain_right = 16'h2000;
        send(24'h000100, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_egr_valid", 32'(bus.egr_valid), 32'd0);
        check("midrst_ing_ready", 32'(bus.ing_ready), 32'd0);
        rst_n          = 1'b1;
        cfg_gain_left  = 16'h1000;
        cfg_gain_right = 16'h1000;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_nothing_emitted", 32'(outq.size()), 32'd0);
        send(24'h000100, 1'b1);
        wait_out(1);
        pop_check("post_rst_unity", beat(1'b1, 24'h000100));
        check("post_rst_single_beat", 32'(outq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
